sa_wresp_channel: RTL and testbench
===================================

SA_WRESP_CHANNEL -- requirements
Module: sa_wresp_channel

Interface
REQ-001 SHALL have parameter MST_AMT, default 2: number of masters (dispatchers) served.
REQ-002 SHALL have parameter OUTSTANDING_AMT, default 8: depth of the master-order FIFO.
REQ-003 SHALL have parameter OUTST_CTN_W, default $clog2(OUTSTANDING_AMT)+1: width of the outstanding counter.
REQ-004 SHALL have parameters TRANS_MST_ID_W (default 5) and TRANS_WR_RESP_W (default 2): BID and BRESP widths.
REQ-005 SHALL have parameter MST_ID_W, default $clog2(MST_AMT): master index width.
REQ-006 SHALL use one clock and an asynchronous, active-low reset.
REQ-007 SHALL have these ports:
- ACLK_i  in  1  clock.
- ARESETn_i  in  1  async active-low reset.
- s_BID_i  in  TRANS_MST_ID_W  slave response ID.
- s_BRESP_i  in  TRANS_WR_RESP_W  slave response code.
- s_BVALID_i  in  1  slave response valid.
- s_BREADY_o  out  1  ready to slave.
- sa_AW_mst_id_i  in  MST_ID_W  granted master of the AW transfer accepted by the slave.
- sa_AW_shift_en_i  in  1  AW handshake to slave occurred; push master id.
- sa_AW_stall_o  out  1  order FIFO full; AW arbiter SHALL NOT grant.
- sa_B_outst_ctn_o  out  OUTST_CTN_W  order FIFO occupancy.
- dsp_BID_o  out  TRANS_MST_ID_W*MST_AMT  per-master BID, slice i for master i.
- dsp_BRESP_o  out  TRANS_WR_RESP_W*MST_AMT  per-master BRESP.
- dsp_BVALID_o  out  MST_AMT  per-master valid.
- dsp_BREADY_i  in  MST_AMT  per-master ready.

Function
REQ-008 SHALL push sa_AW_mst_id_i into the master-order FIFO on every cycle sa_AW_shift_en_i=1 and the FIFO is not full; a push while full SHALL be dropped, and the AW arbiter is responsible for preventing it.
REQ-009 SHALL drive s_BREADY_o = ~order_empty & (~buf_vld | dsp_BREADY_i[buf_mst]).
REQ-010 On a slave handshake (s_BVALID_i & s_BREADY_o), SHALL pop the order FIFO and load the one-entry output buffer as follows: buf_vld=1, buf_mst=FIFO head, and buf_BID/buf_BRESP = s_BID_i/s_BRESP_i.
REQ-011 SHALL drive dsp_BVALID_o[i] = buf_vld & (buf_mst==i); all other bits SHALL be 0.
REQ-012 SHALL drive every dsp_BID_o and dsp_BRESP_o slice from buf_BID and buf_BRESP; only the valid slice is meaningful.
REQ-013 SHALL clear buf_vld on a master handshake (dsp_BVALID_o[buf_mst] & dsp_BREADY_i[buf_mst]) unless a new slave handshake occurs in the same cycle, in which case the buffer reloads (back-to-back, no bubble).
REQ-014 Latency SHALL be 1 cycle from the slave handshake to dsp_BVALID_o.
REQ-015 Throughput SHALL be 1 response per cycle while the destination master holds BREADY=1.
REQ-016 SHALL make a simultaneous push and pop on a non-empty FIFO leave its occupancy unchanged.
REQ-017 SHALL NOT make a push into an empty FIFO visible to s_BREADY_o until the next cycle.
REQ-018 SHALL assert sa_AW_stall_o exactly when occupancy == OUTSTANDING_AMT.
REQ-019 SHALL NOT let a slave BVALID with an empty order FIFO complete a handshake: s_BREADY_o=0.
REQ-020 SHALL hold buffer contents stable while dsp_BVALID_o=1 and ready=0 (AXI stability).
REQ-021 SHALL NOT let BVALID depend combinationally on dsp_BREADY_i.

Reset
REQ-022 On ARESETn_i=0, asynchronously SHALL set: order FIFO empty, sa_B_outst_ctn_o=0, buf_vld=0, dsp_BVALID_o=0, s_BREADY_o=0, sa_AW_stall_o=0.
REQ-023 On reset assertion mid-transfer, SHALL discard buffered and outstanding responses with no further handshake.
REQ-024 SHALL resume operation on the first ACLK_i edge after deassertion.

Structure
REQ-025 SHALL reuse the existing fifo sub-module (DATA_WIDTH=MST_ID_W, FIFO_DEPTH=OUTSTANDING_AMT) for master order, with its counter driving sa_B_outst_ctn_o.
REQ-026 SHALL implement the output buffer and routing in this module.
REQ-027 SHALL take all configuration from parameters; no shared package is needed.

Verification
REQ-028 SHALL cover: push mst 1, then slave B(ID=5, RESP=0) -> dsp_BVALID_o=2'b10 one cycle later, BID slice1=5, count 1->0.
REQ-029 SHALL cover: push 0,1,0 then 3 slave responses with all ready -> dsp_BVALID_o sequence 01,10,01 on consecutive cycles, s_BREADY_o held 1.
REQ-030 SHALL cover: dsp_BREADY_i[0]=0 for 4 cycles -> BVALID/BID/BRESP held stable, s_BREADY_o=0, second slave response stalls until release.
REQ-031 SHALL cover: 8 pushes with none popped -> sa_AW_stall_o=1, count=8; one B completes -> stall=0, count=7.
REQ-032 SHALL cover: s_BVALID_i=1 with empty FIFO -> s_BREADY_o=0, no dsp_BVALID_o; push in the next cycle -> handshake one cycle after the push.
REQ-033 SHALL cover: ARESETn_i low with buf_vld=1 and count=3 -> dsp_BVALID_o=0 and count=0 immediately, with no spurious valid after release.

Source files
------------

// File: rtl/sa_wresp_channel_pkg.sv
// Shared helpers for the write-response channel slice.
package sa_wresp_channel_pkg;

  // Circular pointer increment for FIFOs of arbitrary (not just pow2) depth.
  function automatic int unsigned ptr_inc(input int unsigned ptr, input int unsigned depth);
    return (ptr == depth - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/sa_wresp_channel_fifo.sv
// Synchronous FIFO with occupancy counter. Pushes while full and pops while
// empty are ignored; head data is visible combinationally.
module sa_wresp_channel_fifo
  import sa_wresp_channel_pkg::*;
#(
  parameter int DATA_WIDTH = 1,
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  wr_en_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic                  rd_en_i,
  output logic [DATA_WIDTH-1:0] rd_data_o,
  output logic                  full_o,
  output logic                  empty_o,
  output logic [CNT_W-1:0]      count_o
);
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]      cnt_q;
  logic                  do_wr, do_rd;

  assign full_o    = (cnt_q == CNT_W'(FIFO_DEPTH));
  assign empty_o   = (cnt_q == '0);
  assign count_o   = cnt_q;
  assign rd_data_o = mem_q[rd_ptr_q];
  assign do_wr     = wr_en_i & ~full_o;
  assign do_rd     = rd_en_i & ~empty_o;

  // Storage array; contents are don't-care until written, so no reset.
  always_ff @(posedge clk_i) begin
    if (do_wr) mem_q[wr_ptr_q] <= wr_data_i;
  end

  // Pointer and occupancy bookkeeping; push+pop together leaves count unchanged.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_wr) wr_ptr_q <= PTR_W'(ptr_inc(32'(wr_ptr_q), FIFO_DEPTH));
      if (do_rd) rd_ptr_q <= PTR_W'(ptr_inc(32'(rd_ptr_q), FIFO_DEPTH));
      case ({do_wr, do_rd})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end
endmodule

// File: rtl/sa_wresp_channel.sv
// Slave-side B channel: routes each slave write response back to the master
// whose AW was accepted, in AW order, through a one-entry output buffer.
module sa_wresp_channel
  import sa_wresp_channel_pkg::*;
#(
  parameter int MST_AMT         = 2,
  parameter int OUTSTANDING_AMT = 8,
  parameter int OUTST_CTN_W     = $clog2(OUTSTANDING_AMT) + 1,
  parameter int TRANS_MST_ID_W  = 5,
  parameter int TRANS_WR_RESP_W = 2,
  parameter int MST_ID_W        = $clog2(MST_AMT)
) (
  input  logic                                ACLK_i,
  input  logic                                ARESETn_i,
  input  logic [TRANS_MST_ID_W-1:0]           s_BID_i,
  input  logic [TRANS_WR_RESP_W-1:0]          s_BRESP_i,
  input  logic                                s_BVALID_i,
  output logic                                s_BREADY_o,
  input  logic [MST_ID_W-1:0]                 sa_AW_mst_id_i,
  input  logic                                sa_AW_shift_en_i,
  output logic                                sa_AW_stall_o,
  output logic [OUTST_CTN_W-1:0]              sa_B_outst_ctn_o,
  output logic [TRANS_MST_ID_W*MST_AMT-1:0]   dsp_BID_o,
  output logic [TRANS_WR_RESP_W*MST_AMT-1:0]  dsp_BRESP_o,
  output logic [MST_AMT-1:0]                  dsp_BVALID_o,
  input  logic [MST_AMT-1:0]                  dsp_BREADY_i
);
  logic                       order_empty, order_full;
  logic [MST_ID_W-1:0]        head_mst;
  logic                       s_hs, m_hs, dst_rdy;

  logic                       buf_vld_q, buf_vld_d;
  logic [MST_ID_W-1:0]        buf_mst_q, buf_mst_d;
  logic [TRANS_MST_ID_W-1:0]  buf_bid_q, buf_bid_d;
  logic [TRANS_WR_RESP_W-1:0] buf_bresp_q, buf_bresp_d;

  sa_wresp_channel_fifo #(
    .DATA_WIDTH (MST_ID_W),
    .FIFO_DEPTH (OUTSTANDING_AMT),
    .CNT_W      (OUTST_CTN_W)
  ) u_order_fifo (
    .clk_i     (ACLK_i),
    .rst_ni    (ARESETn_i),
    .wr_en_i   (sa_AW_shift_en_i),
    .wr_data_i (sa_AW_mst_id_i),
    .rd_en_i   (s_hs),
    .rd_data_o (head_mst),
    .full_o    (order_full),
    .empty_o   (order_empty),
    .count_o   (sa_B_outst_ctn_o)
  );

  assign sa_AW_stall_o = order_full;

  // Accept from the slave only when we know the destination and the buffer
  // is free or draining this cycle.
  assign dst_rdy    = dsp_BREADY_i[buf_mst_q];
  assign s_BREADY_o = ~order_empty & (~buf_vld_q | dst_rdy);
  assign s_hs       = s_BVALID_i & s_BREADY_o;
  assign m_hs       = buf_vld_q & dst_rdy;

  // Buffer next state: reload on slave handshake (wins over drain), else drain.
  always_comb begin
    buf_vld_d   = buf_vld_q;
    buf_mst_d   = buf_mst_q;
    buf_bid_d   = buf_bid_q;
    buf_bresp_d = buf_bresp_q;
    if (s_hs) begin
      buf_vld_d   = 1'b1;
      buf_mst_d   = head_mst;
      buf_bid_d   = s_BID_i;
      buf_bresp_d = s_BRESP_i;
    end else if (m_hs) begin
      buf_vld_d   = 1'b0;
    end
  end

  // Output buffer registers; reset discards any pending response.
  always_ff @(posedge ACLK_i or negedge ARESETn_i) begin
    if (!ARESETn_i) begin
      buf_vld_q   <= 1'b0;
      buf_mst_q   <= '0;
      buf_bid_q   <= '0;
      buf_bresp_q <= '0;
    end else begin
      buf_vld_q   <= buf_vld_d;
      buf_mst_q   <= buf_mst_d;
      buf_bid_q   <= buf_bid_d;
      buf_bresp_q <= buf_bresp_d;
    end
  end

  // Fan the buffer out to every master; only the addressed one sees valid.
  for (genvar i = 0; i < MST_AMT; i++) begin : g_mst
    assign dsp_BVALID_o[i] = buf_vld_q & (buf_mst_q == MST_ID_W'(i));
    assign dsp_BID_o[i*TRANS_MST_ID_W +: TRANS_MST_ID_W]     = buf_bid_q;
    assign dsp_BRESP_o[i*TRANS_WR_RESP_W +: TRANS_WR_RESP_W] = buf_bresp_q;
  end
endmodule

// File: tb/tb_sa_wresp_channel.sv
// Directed bench for sa_wresp_channel (MST_AMT=2, depth 8).
module tb_sa_wresp_channel;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [4:0] s_bid = '0;
  logic [1:0] s_bresp = '0;
  logic       s_bvalid = 1'b0;
  logic       s_bready;
  logic       aw_mst = 1'b0;
  logic       aw_shen = 1'b0;
  logic       stall;
  logic [3:0] cnt;
  logic [9:0] d_bid;
  logic [3:0] d_bresp;
  logic [1:0] d_bvalid;
  logic [1:0] d_bready = 2'b11;

  int errors = 0;
  int checks = 0;

  sa_wresp_channel dut (
    .ACLK_i           (clk),
    .ARESETn_i        (rst_n),
    .s_BID_i          (s_bid),
    .s_BRESP_i        (s_bresp),
    .s_BVALID_i       (s_bvalid),
    .s_BREADY_o       (s_bready),
    .sa_AW_mst_id_i   (aw_mst),
    .sa_AW_shift_en_i (aw_shen),
    .sa_AW_stall_o    (stall),
    .sa_B_outst_ctn_o (cnt),
    .dsp_BID_o        (d_bid),
    .dsp_BRESP_o      (d_bresp),
    .dsp_BVALID_o     (d_bvalid),
    .dsp_BREADY_i     (d_bready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle's inputs just after the edge, then let logic settle.
  task automatic step(input logic shen, input logic mst, input logic bv,
                      input logic [4:0] bid, input logic [1:0] br, input logic [1:0] rdy);
    @(posedge clk); #1;
    aw_shen = shen; aw_mst = mst; s_bvalid = bv; s_bid = bid; s_bresp = br; d_bready = rdy;
    #1;
  endtask

  initial begin
    // reset state
    #12;
    chk("rst_bready", s_bready, 0);
    chk("rst_bvalid", d_bvalid, 0);
    chk("rst_cnt", cnt, 0);
    chk("rst_stall", stall, 0);
    @(negedge clk); rst_n = 1'b1;

    // single response to master 1
    step(1, 1, 0, 0, 0, 2'b11);
    chk("s1_push_not_visible", s_bready, 0);
    step(0, 0, 1, 5, 0, 2'b11);
    chk("s1_cnt1", cnt, 1);
    chk("s1_bready", s_bready, 1);
    chk("s1_no_valid_yet", d_bvalid, 0);
    step(0, 0, 0, 0, 0, 2'b11);
    chk("s1_valid", d_bvalid, 2'b10);
    chk("s1_bid1", d_bid[9:5], 5);
    chk("s1_cnt0", cnt, 0);
    step(0, 0, 0, 0, 0, 2'b11);
    chk("s1_drained", d_bvalid, 0);

    // back-to-back 0,1,0
    step(1, 0, 0, 0, 0, 2'b11);
    step(1, 1, 0, 0, 0, 2'b11);
    step(1, 0, 0, 0, 0, 2'b11);
    step(0, 0, 1, 1, 0, 2'b11);
    chk("s2_cnt3", cnt, 3);
    chk("s2_bready_a", s_bready, 1);
    step(0, 0, 1, 2, 1, 2'b11);
    chk("s2_v0", d_bvalid, 2'b01);
    chk("s2_bid0", d_bid[4:0], 1);
    chk("s2_bready_b", s_bready, 1);
    step(0, 0, 1, 3, 2, 2'b11);
    chk("s2_v1", d_bvalid, 2'b10);
    chk("s2_bid1", d_bid[9:5], 2);
    chk("s2_bresp1", d_bresp[3:2], 1);
    chk("s2_bready_c", s_bready, 1);
    step(0, 0, 0, 0, 0, 2'b11);
    chk("s2_v2", d_bvalid, 2'b01);
    chk("s2_bid2", d_bid[4:0], 3);
    chk("s2_cnt0", cnt, 0);
    step(0, 0, 0, 0, 0, 2'b11);
    chk("s2_drained", d_bvalid, 0);

    // backpressure on master 0
    step(1, 0, 0, 0, 0, 2'b10);
    step(1, 0, 0, 0, 0, 2'b10);
    step(0, 0, 1, 7, 2, 2'b10);
    chk("s3_cnt2", cnt, 2);
    chk("s3_bready", s_bready, 1);
    for (int k = 0; k < 4; k++) begin
      step(0, 0, 1, 9, 1, 2'b10);
      chk("s3_hold_v", d_bvalid, 2'b01);
      chk("s3_hold_bid", d_bid[4:0], 7);
      chk("s3_hold_bresp", d_bresp[1:0], 2);
      chk("s3_stalled", s_bready, 0);
      chk("s3_cnt1", cnt, 1);
    end
    step(0, 0, 1, 9, 1, 2'b11);
    chk("s3_release_bready", s_bready, 1);
    chk("s3_release_bid", d_bid[4:0], 7);
    step(0, 0, 0, 0, 0, 2'b11);
    chk("s3_second_v", d_bvalid, 2'b01);
    chk("s3_second_bid", d_bid[4:0], 9);
    chk("s3_second_bresp", d_bresp[1:0], 1);
    chk("s3_cnt0", cnt, 0);
    step(0, 0, 0, 0, 0, 2'b11);
    chk("s3_drained", d_bvalid, 0);

    // fill order FIFO
    for (int k = 0; k < 8; k++) step(1, k[0], 0, 0, 0, 2'b11);
    step(1, 1, 0, 0, 0, 2'b11);
    chk("s4_cnt8", cnt, 8);
    chk("s4_stall", stall, 1);
    step(0, 0, 0, 0, 0, 2'b11);
    chk("s4_drop_cnt8", cnt, 8);
    step(0, 0, 1, 3, 0, 2'b11);
    chk("s4_bready_full", s_bready, 1);
    step(1, 0, 1, 4, 0, 2'b11);
    chk("s4_cnt7", cnt, 7);
    chk("s4_unstall", stall, 0);
    chk("s4_v0", d_bvalid, 2'b01);
    step(0, 0, 1, 4, 0, 2'b11);
    chk("s4_pushpop_cnt7", cnt, 7);
    repeat (6) step(0, 0, 1, 4, 0, 2'b11);
    step(0, 0, 0, 0, 0, 2'b11);
    chk("s4_cnt0", cnt, 0);
    chk("s4_bready_empty", s_bready, 0);
    chk("s4_last_v", d_bvalid, 2'b01);
    step(0, 0, 0, 0, 0, 2'b11);
    chk("s4_drained", d_bvalid, 0);

    // BVALID with empty FIFO
    step(0, 0, 1, 6, 3, 2'b11);
    chk("s5_empty_bready", s_bready, 0);
    chk("s5_empty_v", d_bvalid, 0);
    step(1, 1, 1, 6, 3, 2'b11);
    chk("s5_push_cycle_bready", s_bready, 0);
    step(0, 0, 1, 6, 3, 2'b11);
    chk("s5_next_bready", s_bready, 1);
    chk("s5_cnt1", cnt, 1);
    step(0, 0, 0, 0, 0, 2'b11);
    chk("s5_v1", d_bvalid, 2'b10);
    chk("s5_bid1", d_bid[9:5], 6);
    chk("s5_bresp1", d_bresp[3:2], 3);
    step(0, 0, 0, 0, 0, 2'b11);

    // reset with a held buffer and 3 outstanding
    repeat (4) step(1, 0, 0, 0, 0, 2'b00);
    step(0, 0, 1, 2, 0, 2'b00);
    chk("s6_cnt4", cnt, 4);
    step(0, 0, 1, 2, 0, 2'b00);
    chk("s6_v", d_bvalid, 2'b01);
    chk("s6_cnt3", cnt, 3);
    d_bready = 2'b11;
    rst_n = 1'b0;
    #1;
    chk("s6_rst_v", d_bvalid, 0);
    chk("s6_rst_cnt", cnt, 0);
    chk("s6_rst_bready", s_bready, 0);
    chk("s6_rst_stall", stall, 0);
    @(posedge clk); @(negedge clk);
    rst_n = 1'b1;
    step(0, 0, 1, 2, 0, 2'b11);
    chk("s6_post_bready", s_bready, 0);
    chk("s6_post_v", d_bvalid, 0);
    step(0, 0, 0, 0, 0, 2'b11);
    chk("s6_post_v2", d_bvalid, 0);
    chk("s6_post_cnt", cnt, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
